systolic_mm_ctrl: RTL and testbench

Sequencing controller for one N×N systolic matrix multiply pass. On a start request it clears the PE accumulators and re-arms the skew feeder. It then enables the array for the feed and drain windows and streams the N result rows out over a valid/ready handshake before pulsing done. It sits between the host/command logic and the skew feeder + PE array.

---
 rtl/systolic_mm_ctrl.sv | 146 ++++++++++++++
 tb/tb_systolic_mm_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_mm_ctrl.sv
// systolic_mm_ctrl
// Sequences one N x N systolic matrix-multiply pass: clears the PE accumulators,
// holds the skew feeder in reset until the feed window, enables the array for the
// feed + drain windows, then streams the N result rows out over valid/ready and
// pulses done.
//
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   i_start          start request (sampled only in IDLE)
//   i_abort          synchronous abort, returns to IDLE next cycle
//   o_busy           high in every state except IDLE
//   o_done           one-cycle pulse at pass completion
//   o_err            sticky: feeder not finished at end of drain
//   o_feed_rst_n     feeder reset (released only in FEED and DRAIN)
//   i_feed_finished  feeder finished flag
//   o_pe_clear       PE accumulator clear
//   o_pe_en          PE accumulate/shift enable
//   o_res_row        index of result row currently presented
//   o_res_valid      result row valid
//   i_res_ready      downstream accepts row when valid & ready
module systolic_mm_ctrl #(
    parameter int unsigned N         = 5,
    parameter int unsigned DRAIN_CYC = N,
    parameter int unsigned RW        = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_abort,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_feed_rst_n,
    input  logic          i_feed_finished,
    output logic          o_pe_clear,
    output logic          o_pe_en,
    output logic [RW-1:0] o_res_row,
    output logic          o_res_valid,
    input  logic          i_res_ready
);

    localparam int unsigned FeedCyc = 2 * N - 1;
    localparam int unsigned CntMax  = (FeedCyc > DRAIN_CYC) ? FeedCyc : DRAIN_CYC;
    localparam int unsigned CW      = $clog2(CntMax);

    localparam logic [CW-1:0] FeedLast  = CW'(FeedCyc - 1);
    localparam logic [CW-1:0] DrainLast = CW'(DRAIN_CYC - 1);
    localparam logic [RW-1:0] RowLast   = RW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StFeed,
        StDrain,
        StOut,
        StDone
    } stateT;

    stateT          stateQ, stateD;
    logic [CW-1:0]  cntQ, cntD;
    logic [RW-1:0]  rowQ, rowD;
    logic           errQ, errD;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ <= StIdle;
            cntQ   <= '0;
            rowQ   <= '0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
            rowQ   <= rowD;
            errQ   <= errD;
        end
    end

    always_comb begin
        stateD = stateQ;
        cntD   = '0;
        rowD   = rowQ;
        errD   = errQ;

        case (stateQ)
            StIdle: begin
                if (i_start) stateD = StClear;
            end
            StClear: begin
                errD   = 1'b0;
                stateD = StFeed;
            end
            StFeed: begin
                if (cntQ == FeedLast) stateD = StDrain;
                else                  cntD   = cntQ + 1'b1;
            end
            StDrain: begin
                if (cntQ == DrainLast) begin
                    errD   = !i_feed_finished;
                    stateD = StOut;
                end else begin
                    cntD = cntQ + 1'b1;
                end
            end
            StOut: begin
                if (i_res_ready) begin
                    if (rowQ == RowLast) begin
                        rowD   = '0;
                        stateD = StDone;
                    end else begin
                        rowD = rowQ + 1'b1;
                    end
                end
            end
            StDone: begin
                stateD = StIdle;
            end
            default: begin
                stateD = StIdle;
                rowD   = '0;
            end
        endcase

        // Abort wins over everything, including a start in IDLE; the error flag
        // survives so the host can still inspect it.
        if (i_abort) begin
            stateD = StIdle;
            cntD   = '0;
            rowD   = '0;
            errD   = errQ;
        end
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        o_busy       = (stateQ != StIdle);
        o_done       = (stateQ == StDone);
        o_pe_clear   = (stateQ == StClear);
        o_pe_en      = (stateQ == StFeed) || (stateQ == StDrain);
        o_feed_rst_n = (stateQ == StFeed) || (stateQ == StDrain);
        o_res_valid  = (stateQ == StOut);
    end

    assign o_err     = errQ;
    assign o_res_row = rowQ;

endmodule

// File: tb/tb_systolic_mm_ctrl.sv
module tb_systolic_mm_ctrl;

    localparam int unsigned N  = 5;
    localparam int unsigned RW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_start;
    logic          i_abort;
    logic          o_busy;
    logic          o_done;
    logic          o_err;
    logic          o_feed_rst_n;
    logic          i_feed_finished;
    logic          o_pe_clear;
    logic          o_pe_en;
    logic [RW-1:0] o_res_row;
    logic          o_res_valid;
    logic          i_res_ready;

    int total = 0;
    int bad   = 0;

    systolic_mm_ctrl #(
        .N        (N),
        .DRAIN_CYC(N),
        .RW       (RW)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_start        (i_start),
        .i_abort        (i_abort),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_err          (o_err),
        .o_feed_rst_n   (o_feed_rst_n),
        .i_feed_finished(i_feed_finished),
        .o_pe_clear     (o_pe_clear),
        .o_pe_en        (o_pe_en),
        .o_res_row      (o_res_row),
        .o_res_valid    (o_res_valid),
        .i_res_ready    (i_res_ready)
    );

    always #5 clk = ~clk;

    // {busy, done, err, feed_rst_n, pe_clear, pe_en, res_valid, res_row}
    logic [9:0] obsVec;
    assign obsVec = {o_busy, o_done, o_err, o_feed_rst_n, o_pe_clear, o_pe_en, o_res_valid,
                     o_res_row};

    function automatic logic [9:0] pk(logic b, logic d, logic e, logic f, logic c, logic p,
                                      logic v, int r);
        return {b, d, e, f, c, p, v, 3'(r)};
    endfunction

    // Expected outputs at cycle c of a pass (start sampled at cycle 0) with
    // 'stall' extra cycles holding row 1.
    function automatic logic [9:0] expAt(int c, int stall, logic prevErr, logic errExp);
        logic e;
        int   r;
        e = (c <= 1) ? prevErr : ((c <= 15) ? 1'b0 : errExp);
        if (c == 0 || c >= 22 + stall) return pk(0, 0, e, 0, 0, 0, 0, 0);
        if (c == 1)                    return pk(1, 0, e, 0, 1, 0, 0, 0);
        if (c <= 15)                   return pk(1, 0, e, 1, 0, 1, 0, 0);
        if (c <= 20 + stall) begin
            r = c - 16;
            if (stall > 0 && r > 1) r = (r <= 1 + stall) ? 1 : r - stall;
            return pk(1, 0, e, 0, 0, 0, 1, r);
        end
        return pk(1, 1, e, 0, 0, 0, 0, 0);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [9:0] obs, input logic [9:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Called in an IDLE cycle ("cycle 0"); returns in the IDLE cycle after DONE.
    task automatic runPass(input int stall, input logic fin, input logic prevErr,
                           input logic errExp, input logic pulses, input string tag);
        i_start         = 1'b1;
        i_feed_finished = fin;
        i_res_ready     = 1'b1;
        for (int c = 1; c <= 22 + stall; c++) begin
            step();
            i_start     = pulses && (c == 5 || c == 17);
            i_res_ready = !(stall > 0 && c >= 17 && c <= 19);
            chk($sformatf("%s c%0d", tag, c), obsVec, expAt(c, stall, prevErr, errExp));
        end
        i_start     = 1'b0;
        i_res_ready = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        i_start         = 1'b0;
        i_abort         = 1'b0;
        i_feed_finished = 1'b0;
        i_res_ready     = 1'b1;
        step();
        step();
        chk("reset", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;

        // Nominal pass, then backpressure on rows 1..
        runPass(0, 1'b1, 1'b0, 1'b0, 1'b0, "nominal");
        runPass(3, 1'b1, 1'b0, 1'b0, 1'b0, "backpressure");

        // Feeder never finishes: err set, pass still completes.
        runPass(0, 1'b0, 1'b0, 1'b1, 1'b0, "feed_err");

        // Abort in CLEAR keeps err.
        i_start = 1'b1;
        step();
        chk("abort_clr c1", obsVec, pk(1, 0, 1, 0, 1, 0, 0, 0));
        i_start = 1'b0;
        i_abort = 1'b1;
        step();
        chk("abort_clr c2", obsVec, pk(0, 0, 1, 0, 0, 0, 0, 0));

        // Start and abort together in IDLE.
        i_start = 1'b1;
        step();
        chk("start_abort c1", obsVec, pk(0, 0, 1, 0, 0, 0, 0, 0));
        i_start = 1'b0;
        i_abort = 1'b0;
        step();
        chk("start_abort c2", obsVec, pk(0, 0, 1, 0, 0, 0, 0, 0));

        // Next start clears err in CLEAR.
        runPass(0, 1'b1, 1'b1, 1'b0, 1'b0, "err_clear");

        // Abort during FEED.
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 8; c++) step();
        chk("abort_feed c8", obsVec, pk(1, 0, 0, 1, 0, 1, 0, 0));
        i_abort = 1'b1;
        step();
        chk("abort_feed c9", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));
        i_abort = 1'b0;
        step();
        chk("abort_feed c10", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));

        // Full pass after abort (counter must restart) with stray start pulses.
        runPass(0, 1'b1, 1'b0, 1'b0, 1'b1, "busy_start");

        // Reset at cycle 12 (DRAIN).
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 12; c++) step();
        rst_n = 1'b0;
        step();
        chk("rst_mid c13", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b1;
        step();
        chk("rst_mid c14", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));

        // Reset during OUT with err set clears err.
        i_start         = 1'b1;
        i_feed_finished = 1'b0;
        step();
        i_start = 1'b0;
        for (int c = 2; c <= 17; c++) step();
        chk("rst_err c17", obsVec, pk(1, 0, 1, 0, 0, 0, 1, 1));
        rst_n = 1'b0;
        step();
        chk("rst_err c18", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n           = 1'b1;
        i_feed_finished = 1'b1;

        // Back-to-back: start held high, period 22 cycles.
        i_start = 1'b1;
        for (int c = 1; c <= 43; c++) begin
            step();
            if (c == 43) i_start = 1'b0;
            chk($sformatf("b2b c%0d", c), obsVec, expAt(((c - 1) % 22) + 1, 0, 1'b0, 1'b0));
        end
        step();
        chk("b2b c44", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));
        step();
        chk("b2b c45", obsVec, pk(0, 0, 0, 0, 0, 0, 0, 0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
